input_loader: RTL

Byte-serial front end that fills the binary image and first-layer kernel registers consumed by the first convolution layer. While the top-level FSM is in the load state, it accepts 8-bit beats over a valid/ready handshake: 9 weight bytes first, then 98 pixel bytes. It then raises `load_done` and holds both registers stable for the compute layers.

---
 rtl/input_loader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/input_loader.sv
// input_loader: byte-serial front end that fills the first-layer kernel
// register and the binary image register. A load is 9 weight bytes followed
// by 98 pixel bytes over a valid/ready handshake. The completed image and
// kernel set are then held stable for the compute layers.
module input_loader #(
  parameter int N_WGT_BYTES = 9,
  parameter int N_PIX_BYTES = 98
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2:0]                 state,
  input  logic [7:0]                 data_in,
  input  logic                       data_valid,
  output logic                       data_ready,
  output logic [8*N_WGT_BYTES-1:0]   weights,
  output logic [8*N_PIX_BYTES-1:0]   pixels,
  output logic                       load_done,
  output logic                       overflow_err
);

  localparam logic [2:0] S_LOAD = 3'b001;

  // Loader FSM encoding. HOLD is DONE after the top-level FSM has left
  // s_LOAD, so a later return to s_LOAD can be told apart from staying in it.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WGT  = 3'd1;
  localparam logic [2:0] ST_PIX  = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_HOLD = 3'd4;

  localparam logic [6:0] LAST_WGT = 7'(N_WGT_BYTES - 1);
  localparam logic [6:0] LAST_PIX = 7'(N_PIX_BYTES - 1);

  logic [2:0]               state_q, state_d;
  logic [6:0]               cnt_q, cnt_d;
  logic [8*N_WGT_BYTES-1:0] weights_q, weights_d;
  logic [8*N_PIX_BYTES-1:0] pixels_q, pixels_d;
  logic                     done_q, done_d;
  logic                     ovf_q, ovf_d;
  logic                     in_load;

  assign in_load = (state == S_LOAD);

  // Ready is a pure decode of the registered FSM state; no path from valid.
  assign data_ready = (state_q == ST_WGT) || (state_q == ST_PIX);

  // Next-state, counter and byte-lane write logic.
  always_comb begin
    // NOTE: every variable gets its current value first so no path through
    // the case below can leave one unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    weights_d = weights_q;
    pixels_d  = pixels_q;
    done_d    = done_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      ST_IDLE, ST_HOLD: begin
        // Any (re-)entry to s_LOAD starts a fresh load at weight byte 0.
        if (in_load) begin
          state_d = ST_WGT;
          cnt_d   = '0;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end

      ST_WGT: begin
        if (!in_load) begin
          // Abort wins over a beat offered on the same edge.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (data_valid) begin
          for (int k = 0; k < N_WGT_BYTES; k++) begin
            if (cnt_q == 7'(k)) weights_d[8*k +: 8] = data_in;
          end
          if (cnt_q == LAST_WGT) begin
            state_d = ST_PIX;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end

      ST_PIX: begin
        if (!in_load) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (data_valid) begin
          for (int m = 0; m < N_PIX_BYTES; m++) begin
            if (cnt_q == 7'(m)) pixels_d[8*m +: 8] = data_in;
          end
          cnt_d = cnt_q + 7'd1;
          if (cnt_q == LAST_PIX) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end

      ST_DONE: begin
        // Beats offered after completion are dropped and flagged.
        if (in_load && data_valid) ovf_d = 1'b1;
        if (!in_load) state_d = ST_HOLD;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers, including the wide data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      // NOTE: the data registers are reset too (unlike a typical RAM) because
      // the compute layers must see all-zero weights and pixels after reset.
      weights_q <= '0;
      pixels_q  <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // same pre-edge values regardless of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      weights_q <= weights_d;
      pixels_q  <= pixels_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign weights      = weights_q;
  assign pixels       = pixels_q;
  assign load_done    = done_q;
  assign overflow_err = ovf_q;

endmodule
